tcam_ctrl: RTL and testbench
============================

TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, which is the number of cycles from the search-issue edge until in_tcam_pma is valid (legal range 1..3).
REQ-002 SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_rstb, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports in_wr_valid (input, 1), out_wr_ready (output, 1), in_wr_addr (input, 28), in_wr_wdata (input, 32) and in_wr_wmask (input, 4): the write request channel.
REQ-005 SHALL have ports in_srch_valid (input, 1), out_srch_ready (output, 1) and in_srch_key (input, 28): the search request channel.
REQ-006 SHALL have ports out_rsp_valid (output, 1), in_rsp_ready (input, 1) and out_rsp_pma (output, 6): the search response channel.
REQ-007 SHALL have ports out_tcam_csb (output, 1), out_tcam_web (output, 1), out_tcam_wmask (output, 4), out_tcam_addr (output, 28) and out_tcam_wdata (output, 32): the TCAM drive port; all are registered.
REQ-008 SHALL have port in_tcam_pma, input, 6 bits: the TCAM priority-match address.
REQ-009 SHALL have port out_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, WRITE, SEARCH, WAIT and RESP.
REQ-011 In IDLE the ready outputs SHALL be driven by the arbiter; in every other state both ready outputs SHALL be 0.
- A ready may depend on the other channel's valid.
REQ-012 A transfer SHALL occur when valid and ready are both high; the request payload is registered at that edge.
REQ-013 When only one channel is valid in IDLE, that channel SHALL be granted.
REQ-014 When both channels are valid in IDLE, the channel selected by the round-robin pointer SHALL be granted.
- The pointer moves to the other channel after every grant.
- The pointer resets to favour the write channel.
REQ-015 A write fire SHALL cause a transition IDLE->WRITE.
- The WRITE state drives csb=0, web=0 and the registered addr/wdata/wmask for exactly 1 cycle.
- WRITE then transitions to IDLE.
- Minimum write period is 2 cycles.
REQ-016 A search fire SHALL cause a transition IDLE->SEARCH.
- The SEARCH state drives csb=0, web=1, addr=key and wdata=0 for exactly 1 cycle.
- SEARCH then transitions to WAIT.
REQ-017 WAIT SHALL count RD_LATENCY cycles on a 2-bit down-counter.
- On the last WAIT cycle, in_tcam_pma is captured into out_rsp_pma.
- The state then moves to RESP.
REQ-018 In RESP, out_rsp_valid SHALL be 1 and out_rsp_pma SHALL be held stable until in_rsp_ready=1.
- On that handshake the state returns to IDLE.
REQ-019 Responses SHALL be issued in request order, with at most one outstanding search.
- Any write accepted after a search therefore takes effect only after that search's response is consumed.
REQ-020 Outside WRITE and SEARCH, the TCAM drive port SHALL hold its idle value: csb=1, web=1, wmask=0, addr=0, wdata=0.
REQ-021 Ready-to-valid latency SHALL be 0 cycles in IDLE; request fire to TCAM drive SHALL be 1 cycle.
REQ-022 Search fire to out_rsp_valid SHALL be RD_LATENCY+2 cycles.
REQ-023 Payload fields SHALL pass unmodified at full width; no truncation or extension is permitted.
REQ-024 in_rsp_ready asserted while out_rsp_valid=0 SHALL have no effect.

Reset
REQ-025 While in_rstb=0 at a clock edge, the block SHALL enter IDLE, set the round-robin pointer to the write channel and clear the wait counter.
REQ-026 The outputs SHALL take these reset values: out_rsp_valid=0, out_rsp_pma=0, out_busy=0, and the TCAM drive port at its idle value.
REQ-027 Reset asserted mid-operation (WRITE, SEARCH, WAIT or RESP) SHALL abort the operation and discard any pending response.
- The TCAM returns to idle at the same edge.
REQ-028 The ready outputs SHALL be 0 while in_rstb=0.

Structure
REQ-029 Shared package tcam_pkg SHALL hold:
- the state enum tcam_ctrl_state_t;
- the constants TCAM_ADDR_W=28, TCAM_DATA_W=32, TCAM_MASK_W=4 and TCAM_PMA_W=6.
REQ-030 Two-way round-robin arbitration SHALL be one sub-module, tcam_rr_arb2, with inputs req[1:0] and advance, and output grant[1:0].
- Its pointer register lives inside it.
REQ-031 No other sub-modules; the FSM, counter and output registers live in tcam_ctrl.

Verification
REQ-032 Write: wr_valid with addr=0x0000_1A5, wdata=0xDEAD_BEEF, wmask=0xF -> next cycle csb=0, web=0, addr=0x1A5, wdata=0xDEADBEEF, wmask=0xF; the following cycle csb=1 and wr_ready=1.
REQ-033 Search (RD_LATENCY=1): key=0x0ABC_DEF with in_tcam_pma=6'd37 during WAIT -> out_rsp_valid rises 3 cycles after fire with pma=37.
REQ-034 Backpressure: hold in_rsp_ready=0 for 5 cycles -> rsp_valid and pma stay constant and both ready outputs stay 0; in_rsp_ready=1 -> IDLE next cycle.
REQ-035 Arbitration: wr_valid and srch_valid held high continuously after reset -> grants alternate W, S, W, S, with no TCAM cycle on which csb=0 and both operations overlap.
REQ-036 Reset mid-WAIT: drop in_rstb during WAIT -> next edge csb=1, rsp_valid=0 and busy=0; no response appears after reset is released.
REQ-037 RD_LATENCY=3: search fire -> rsp_valid 5 cycles later, with the pma sampled on the 3rd WAIT cycle.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared types and widths for the TCAM controller and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcam_pkg;

  localparam int TCAM_ADDR_W = 28;
  localparam int TCAM_DATA_W = 32;
  localparam int TCAM_MASK_W = 4;
  localparam int TCAM_PMA_W  = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    SEARCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } tcam_ctrl_state_t;

  // Everything the controller presents to the TCAM macro in one cycle.
  typedef struct packed {
    logic                   csb;
    logic                   web;
    logic [TCAM_MASK_W-1:0] wmask;
    logic [TCAM_ADDR_W-1:0] addr;
    logic [TCAM_DATA_W-1:0] wdata;
  } tcam_drv_t;

  // Deselected macro: chip select and write enable inactive, buses parked at zero.
  localparam tcam_drv_t TCAM_DRV_IDLE = '{
    csb:   1'b1,
    web:   1'b1,
    wmask: '0,
    addr:  '0,
    wdata: '0
  };

endpackage

// File: rtl/tcam_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = write channel, bit 1 = search channel.
// Latency: grant is combinational from req; the pointer updates on the advance edge.
// Backpressure: none internally; the caller qualifies grant with its own idle condition.
//
// Ports:
//   in_clk, in_rstb : clock and synchronous active-low reset (pointer -> write favoured)
//   req[1:0]        : per-channel request (the channel valids)
//   advance         : a grant was taken this cycle; the pointer moves away from the winner
//   grant[1:0]      : a channel is granted unless the other one also requests and holds
//                     priority, so an idle channel still sees grant (ready before valid)
module tcam_rr_arb2 (
  input  logic       in_clk,
  input  logic       in_rstb,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_ptr;       // 0: write favoured on contention, 1: search favoured
  logic w_wr_taken;

  always_comb begin
    grant[0] = ~req[1] | (req[0] & ~r_ptr);
    grant[1] = ~req[0] | (req[1] &  r_ptr);
  end

  assign w_wr_taken = req[0] & grant[0];

  // After a write win the search side is favoured next, and vice versa.
  always_ff @(posedge in_clk) begin
    if (!in_rstb) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= w_wr_taken;
    end
  end

endmodule

// File: rtl/tcam_ctrl.sv
// TCAM controller: arbitrates write and search requests onto one TCAM port, returns search PMA.
// Latency: fire -> TCAM drive 1 cycle; search fire -> out_rsp_valid RD_LATENCY+2 cycles.
// Backpressure: both request readies drop while busy; the response is held until in_rsp_ready.
//
// Ports:
//   in_clk, in_rstb                       : clock, synchronous active-low reset
//   in_wr_valid/out_wr_ready + payload    : write request (addr, wdata, wmask)
//   in_srch_valid/out_srch_ready + key    : search request
//   out_rsp_valid/in_rsp_ready/out_rsp_pma: search response
//   out_tcam_*                            : registered TCAM drive port
//   in_tcam_pma                           : TCAM priority-match address, valid RD_LATENCY
//                                           cycles after the search-issue edge
//   out_busy                              : controller not in IDLE
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                   in_clk,
  input  logic                   in_rstb,
  input  logic                   in_wr_valid,
  output logic                   out_wr_ready,
  input  logic [TCAM_ADDR_W-1:0] in_wr_addr,
  input  logic [TCAM_DATA_W-1:0] in_wr_wdata,
  input  logic [TCAM_MASK_W-1:0] in_wr_wmask,
  input  logic                   in_srch_valid,
  output logic                   out_srch_ready,
  input  logic [TCAM_ADDR_W-1:0] in_srch_key,
  output logic                   out_rsp_valid,
  input  logic                   in_rsp_ready,
  output logic [TCAM_PMA_W-1:0]  out_rsp_pma,
  output logic                   out_tcam_csb,
  output logic                   out_tcam_web,
  output logic [TCAM_MASK_W-1:0] out_tcam_wmask,
  output logic [TCAM_ADDR_W-1:0] out_tcam_addr,
  output logic [TCAM_DATA_W-1:0] out_tcam_wdata,
  input  logic [TCAM_PMA_W-1:0]  in_tcam_pma,
  output logic                   out_busy
);

  // The WAIT counter holds RD_LATENCY-1 on entry and RESP follows when it reaches zero.
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  tcam_ctrl_state_t r_state;
  tcam_ctrl_state_t w_state_nxt;
  logic [1:0]       r_wait_cnt;
  tcam_drv_t        r_drv;
  tcam_drv_t        w_drv_nxt;
  logic [TCAM_PMA_W-1:0] r_rsp_pma;

  logic       w_idle;
  logic [1:0] w_grant;
  logic       w_wr_fire;
  logic       w_srch_fire;
  logic       w_wait_last;

  tcam_rr_arb2 u_arb (
    .in_clk  (in_clk),
    .in_rstb (in_rstb),
    .req     ({in_srch_valid, in_wr_valid}),
    .advance (w_wr_fire | w_srch_fire),
    .grant   (w_grant)
  );

  assign w_wr_fire   = in_wr_valid   & out_wr_ready;
  assign w_srch_fire = in_srch_valid & out_srch_ready;
  assign w_wait_last = (r_state == WAIT) && (r_wait_cnt == 2'd0);

  // ---------------- state register ----------------
  always_ff @(posedge in_clk) begin
    if (!in_rstb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_fire) begin
          w_state_nxt = WRITE;
        end else if (w_srch_fire) begin
          w_state_nxt = SEARCH;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      SEARCH:  w_state_nxt = WAIT;
      WAIT: begin
        if (w_wait_last) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (in_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  // Readies are gated by reset directly so they are low for the whole reset window,
  // not just from the first reset edge onward.
  always_comb begin
    w_idle         = (r_state == IDLE);
    out_wr_ready   = in_rstb & w_idle & w_grant[0];
    out_srch_ready = in_rstb & w_idle & w_grant[1];
    out_rsp_valid  = (r_state == RESP);
    out_busy       = ~w_idle;
  end

  // The drive register is loaded from the next state, so the one-cycle WRITE/SEARCH
  // strobe lines up with the state and the payload is captured on the fire edge.
  always_comb begin
    w_drv_nxt = TCAM_DRV_IDLE;
    if (w_state_nxt == WRITE) begin
      w_drv_nxt.csb   = 1'b0;
      w_drv_nxt.web   = 1'b0;
      w_drv_nxt.wmask = in_wr_wmask;
      w_drv_nxt.addr  = in_wr_addr;
      w_drv_nxt.wdata = in_wr_wdata;
    end else if (w_state_nxt == SEARCH) begin
      w_drv_nxt.csb   = 1'b0;
      w_drv_nxt.web   = 1'b1;
      w_drv_nxt.addr  = in_srch_key;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rstb) begin
      r_drv <= TCAM_DRV_IDLE;
    end else begin
      r_drv <= w_drv_nxt;
    end
  end

  // ---------------- wait counter ----------------
  always_ff @(posedge in_clk) begin
    if (!in_rstb) begin
      r_wait_cnt <= 2'd0;
    end else if (r_state == SEARCH) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if ((r_state == WAIT) && (r_wait_cnt != 2'd0)) begin
      r_wait_cnt <= r_wait_cnt - 2'd1;
    end
  end

  // ---------------- response capture ----------------
  // Sampled only on the last WAIT cycle; held unchanged through RESP backpressure.
  always_ff @(posedge in_clk) begin
    if (!in_rstb) begin
      r_rsp_pma <= '0;
    end else if (w_wait_last) begin
      r_rsp_pma <= in_tcam_pma;
    end
  end

  assign out_rsp_pma    = r_rsp_pma;
  assign out_tcam_csb   = r_drv.csb;
  assign out_tcam_web   = r_drv.web;
  assign out_tcam_wmask = r_drv.wmask;
  assign out_tcam_addr  = r_drv.addr;
  assign out_tcam_wdata = r_drv.wdata;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Self-checking bench for tcam_ctrl: ready table, directed corner sequences,
// random traffic against a transaction-level model, and an RD_LATENCY=3 instance.
module tb_tcam_ctrl;

  localparam int RL1 = 1;

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // ---------------- DUT with RD_LATENCY=1 ----------------
  logic        rstb, wr_valid, wr_ready, srch_valid, srch_ready;
  logic        rsp_valid, rsp_ready, t_csb, t_web, busy;
  logic [27:0] wr_addr, srch_key, t_addr;
  logic [31:0] wr_wdata, t_wdata;
  logic [3:0]  wr_wmask, t_wmask;
  logic [5:0]  rsp_pma, t_pma;
  logic [65:0] drv1;
  assign drv1 = {t_csb, t_web, t_wmask, t_addr, t_wdata};

  tcam_ctrl #(.RD_LATENCY(RL1)) u_dut1 (
    .in_clk(in_clk), .in_rstb(rstb),
    .in_wr_valid(wr_valid), .out_wr_ready(wr_ready), .in_wr_addr(wr_addr),
    .in_wr_wdata(wr_wdata), .in_wr_wmask(wr_wmask),
    .in_srch_valid(srch_valid), .out_srch_ready(srch_ready), .in_srch_key(srch_key),
    .out_rsp_valid(rsp_valid), .in_rsp_ready(rsp_ready), .out_rsp_pma(rsp_pma),
    .out_tcam_csb(t_csb), .out_tcam_web(t_web), .out_tcam_wmask(t_wmask),
    .out_tcam_addr(t_addr), .out_tcam_wdata(t_wdata), .in_tcam_pma(t_pma),
    .out_busy(busy)
  );

  // ---------------- DUT with RD_LATENCY=3 ----------------
  logic        d3_rstb, d3_wr_valid, d3_wr_ready, d3_srch_valid, d3_srch_ready;
  logic        d3_rsp_valid, d3_rsp_ready, d3_csb, d3_web, d3_busy;
  logic [27:0] d3_wr_addr, d3_key, d3_addr;
  logic [31:0] d3_wr_wdata, d3_wdata;
  logic [3:0]  d3_wr_wmask, d3_wmask;
  logic [5:0]  d3_rsp_pma, d3_pma;

  tcam_ctrl #(.RD_LATENCY(3)) u_dut3 (
    .in_clk(in_clk), .in_rstb(d3_rstb),
    .in_wr_valid(d3_wr_valid), .out_wr_ready(d3_wr_ready), .in_wr_addr(d3_wr_addr),
    .in_wr_wdata(d3_wr_wdata), .in_wr_wmask(d3_wr_wmask),
    .in_srch_valid(d3_srch_valid), .out_srch_ready(d3_srch_ready), .in_srch_key(d3_key),
    .out_rsp_valid(d3_rsp_valid), .in_rsp_ready(d3_rsp_ready), .out_rsp_pma(d3_rsp_pma),
    .out_tcam_csb(d3_csb), .out_tcam_web(d3_web), .out_tcam_wmask(d3_wmask),
    .out_tcam_addr(d3_addr), .out_tcam_wdata(d3_wdata), .in_tcam_pma(d3_pma),
    .out_busy(d3_busy)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  localparam logic [65:0] DRV_IDLE = {1'b1, 1'b1, 4'h0, 28'h0, 32'h0};

  // Ready table, applied combinationally inside one IDLE cycle with the pointer at write.
  typedef struct {
    string name;
    logic  rstb, wv, sv;
    logic  e_wr, e_sr;
  } rdy_vec_t;
  rdy_vec_t vecs[4];

  // Transaction-level reference model state for the random phase.
  int          m_drv_cyc, m_pma_cyc, m_rsp_from;
  logic [65:0] m_drv;
  logic        m_srch_open, m_ptr_srch, m_idle, e_rv;
  logic [5:0]  m_pma;
  logic [1:0]  e_fire, a_fire;
  logic [1:0]  got[4];
  logic [1:0]  last_fire;
  int          grants, rv_seen, lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstb = 0; wr_valid = 0; srch_valid = 0; rsp_ready = 0;
    wr_addr = '0; wr_wdata = '0; wr_wmask = '0; srch_key = '0; t_pma = '0;
    d3_rstb = 0; d3_wr_valid = 0; d3_srch_valid = 0; d3_rsp_ready = 0;
    d3_wr_addr = '0; d3_wr_wdata = '0; d3_wr_wmask = '0; d3_key = '0; d3_pma = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_pma", rsp_pma, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_drive", drv1, DRV_IDLE);

    vecs[0] = '{"rdy_in_reset",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"rdy_wr_only",    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"rdy_srch_only",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"rdy_both_ptr_w", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rstb = vecs[i].rstb; wr_valid = vecs[i].wv; srch_valid = vecs[i].sv;
      #1;
      check({vecs[i].name, "_wr"}, wr_ready, vecs[i].e_wr);
      check({vecs[i].name, "_sr"}, srch_ready, vecs[i].e_sr);
    end
    wr_valid = 0; srch_valid = 0; rstb = 1;
    tick();

    // ---------------- single write ----------------
    wr_valid = 1; wr_addr = 28'h00001A5; wr_wdata = 32'hDEADBEEF; wr_wmask = 4'hF;
    tick();
    wr_valid = 0; wr_addr = '0; wr_wdata = '0; wr_wmask = '0;
    check("wr_drive", drv1, {1'b0, 1'b0, 4'hF, 28'h00001A5, 32'hDEADBEEF});
    check("wr_busy", busy, 1'b1);
    check("wr_rdy_during", wr_ready, 1'b0);
    tick();
    check("wr_csb_after", t_csb, 1'b1);
    check("wr_rdy_after", wr_ready, 1'b1);
    check("wr_busy_after", busy, 1'b0);

    // ---------------- single search, RD_LATENCY=1 ----------------
    srch_valid = 1; srch_key = 28'h0ABCDEF;
    tick();                       // SEARCH cycle (fire cycle + 1)
    srch_valid = 0; srch_key = '0; t_pma = 6'd5;
    check("srch_drive", drv1, {1'b0, 1'b1, 4'h0, 28'h0ABCDEF, 32'h0});
    tick();                       // WAIT cycle (fire + 2), the one the PMA is sampled in
    t_pma = 6'd37;
    check("srch_wait_drive", drv1, DRV_IDLE);
    check("srch_wait_rv", rsp_valid, 1'b0);
    tick();                       // fire + 3
    t_pma = 6'd9;
    check("srch_rv", rsp_valid, 1'b1);
    check("srch_pma", rsp_pma, 6'd37);

    // ---------------- response backpressure ----------------
    wr_valid = 1; srch_valid = 1;
    for (int i = 0; i < 5; i++) begin
      t_pma = 6'(i + 20);
      #1;
      check("bp_rv", rsp_valid, 1'b1);
      check("bp_pma", rsp_pma, 6'd37);
      check("bp_readies", {wr_ready, srch_ready}, 2'b00);
      tick();
    end
    wr_valid = 0; srch_valid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_rv", rsp_valid, 1'b0);

    // ---------------- contention straight after reset ----------------
    rstb = 0; tick(); rstb = 1;
    wr_valid = 1; srch_valid = 1; rsp_ready = 1;
    grants = 0; last_fire = 2'b00;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      wr_addr = 28'($urandom); wr_wdata = $urandom; wr_wmask = 4'($urandom);
      srch_key = 28'($urandom); t_pma = 6'($urandom);
      #1;
      if (last_fire == 2'b01)      check("arb_drive_w", {t_csb, t_web}, 2'b00);
      else if (last_fire == 2'b10) check("arb_drive_s", {t_csb, t_web}, 2'b01);
      else                         check("arb_drive_idle", t_csb, 1'b1);
      last_fire = {srch_valid & srch_ready, wr_valid & wr_ready};
      if (last_fire != 2'b00) begin
        got[grants] = last_fire;
        grants++;
      end
      tick();
    end
    check("arb_grant_count", grants, 4);
    check("arb_g0_w", got[0], 2'b01);
    check("arb_g1_s", got[1], 2'b10);
    check("arb_g2_w", got[2], 2'b01);
    check("arb_g3_s", got[3], 2'b10);
    wr_valid = 0; srch_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    rsp_ready = 0;

    // ---------------- reset during WAIT ----------------
    srch_valid = 1; srch_key = 28'h0000123;
    tick();                       // SEARCH
    srch_valid = 0;
    tick();                       // WAIT
    check("rw_busy_pre", busy, 1'b1);
    rstb = 0; srch_valid = 1;
    tick();
    check("rw_csb", t_csb, 1'b1);
    check("rw_rv", rsp_valid, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_srch_rdy", srch_ready, 1'b0);
    srch_valid = 0; rstb = 1;
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) rv_seen++;
    end
    check("rw_no_late_rsp", rv_seen, 0);

    // ---------------- random traffic vs reference model ----------------
    rstb = 0; tick(); rstb = 1;
    m_drv_cyc = -1; m_pma_cyc = -1; m_rsp_from = 0; m_drv = DRV_IDLE;
    m_srch_open = 0; m_ptr_srch = 0; m_pma = '0;
    for (int t = 0; t < 500; t++) begin
      wr_valid = 1'($urandom); srch_valid = 1'($urandom);
      wr_addr = 28'($urandom); wr_wdata = $urandom; wr_wmask = 4'($urandom);
      srch_key = 28'($urandom); rsp_ready = ($urandom_range(0, 3) != 0);
      t_pma = 6'($urandom);
      #1;
      check("rnd_drive", drv1, (t == m_drv_cyc) ? m_drv : DRV_IDLE);
      e_rv = m_srch_open && (t >= m_rsp_from);
      check("rnd_rsp_valid", rsp_valid, e_rv);
      if (e_rv) check("rnd_rsp_pma", rsp_pma, m_pma);
      m_idle = !((t == m_drv_cyc) || m_srch_open);
      check("rnd_busy", busy, !m_idle);
      if (!m_idle)                     e_fire = 2'b00;
      else if (wr_valid && srch_valid) e_fire = m_ptr_srch ? 2'b10 : 2'b01;
      else                             e_fire = {srch_valid, wr_valid};
      a_fire = {srch_valid & srch_ready, wr_valid & wr_ready};
      check("rnd_fire", a_fire, e_fire);
      if (!m_idle) check("rnd_rdy_busy", {wr_ready, srch_ready}, 2'b00);
      if (t == m_pma_cyc) m_pma = t_pma;
      if (e_rv && rsp_ready) m_srch_open = 0;
      if (e_fire == 2'b01) begin
        m_drv_cyc = t + 1;
        m_drv = {1'b0, 1'b0, wr_wmask, wr_addr, wr_wdata};
        m_ptr_srch = 1;
      end else if (e_fire == 2'b10) begin
        m_drv_cyc = t + 1;
        m_drv = {1'b0, 1'b1, 4'h0, srch_key, 32'h0};
        m_srch_open = 1;
        m_pma_cyc = t + RL1 + 1;
        m_rsp_from = t + RL1 + 2;
        m_ptr_srch = 0;
      end
      tick();
    end
    wr_valid = 0; srch_valid = 0; rsp_ready = 0;

    // ---------------- RD_LATENCY=3 search ----------------
    d3_rstb = 1;
    tick();
    d3_srch_valid = 1; d3_key = 28'h5A5A5A5;
    tick();                       // cycle 1 after the fire cycle: SEARCH
    d3_srch_valid = 0; d3_key = '0;
    check("rl3_drive", {d3_csb, d3_web, d3_addr}, {1'b0, 1'b1, 28'h5A5A5A5});
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      d3_pma = (c == 4) ? 6'd50 : 6'(c);   // cycle 4 is the third WAIT cycle
      #1;
      if (d3_rsp_valid) lat = c;
      else tick();
    end
    check("rl3_latency", lat, 5);
    check("rl3_pma", d3_rsp_pma, 6'd50);
    d3_rsp_ready = 1;
    tick();
    d3_rsp_ready = 0;
    check("rl3_idle", d3_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
